// File: rtl/klingon_pkg.sv
// Shared constants and types for the Klingon display counter/scanner.
package klingon_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam logic [3:0]  BCD_MAX    = 4'd9;
   localparam logic [3:0]  AN_IDLE    = 4'b1110;

   typedef logic [3:0] bcd_t;

   // Active-low one-hot anode pattern for a display position.
   function automatic logic [3:0] an_pattern(input logic [1:0] sel);
      return ~(4'b0001 << sel);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal counter digit; rolls 9 -> 0 and raises carry on that increment.
module bcd_digit
   import klingon_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output bcd_t q,
   output logic carry
);

   bcd_t r_q;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_q <= '0;
      end else if (inc) begin
         r_q <= (r_q == BCD_MAX) ? '0 : r_q + 4'd1;
      end
   end

   assign q     = r_q;
   assign carry = inc & (r_q == BCD_MAX);

endmodule

// File: rtl/klingon_scan.sv
// Four-digit BCD counter with prescaler and time-multiplexed, registered display scan.
module klingon_scan
   import klingon_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 1000,
   parameter int unsigned COUNT_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       clr,
   output logic [3:0] digit,
   output logic [3:0] an,
   output logic       wrap
);

   localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam int unsigned SW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

   logic [PW-1:0]       r_presc;
   logic [SW-1:0]       r_scan;
   logic [1:0]          r_sel;
   logic [3:0]          r_digit;
   logic [3:0]          r_an;
   logic                r_wrap_pend;
   logic                r_wrap;
   logic                w_tick;
   logic [NUM_DIGITS:0] w_inc;
   bcd_t                w_q [NUM_DIGITS];

   assign w_tick = en & (r_presc == PRESC_LAST);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_presc <= '0;
      end else if (en) begin
         r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end
   end

   // Decimal ripple: each digit's carry-out increments the next one up.
   assign w_inc[0] = w_tick;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .clk   (clk),
         .reset (reset),
         .clr   (clr),
         .inc   (w_inc[g]),
         .q     (w_q[g]),
         .carry (w_inc[g+1])
      );
   end

   // Rollover lands at edge N; the pulse is shown on the following edge, aligned with digit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrap_pend <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         r_wrap_pend <= w_inc[NUM_DIGITS] & ~clr;
         r_wrap      <= r_wrap_pend;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_scan <= '0;
         r_sel  <= 2'd0;
      end else if (r_scan == SCAN_LAST) begin
         r_scan <= '0;
         r_sel  <= r_sel + 2'd1;
      end else begin
         r_scan <= r_scan + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_digit <= 4'd0;
         r_an    <= AN_IDLE;
      end else begin
         r_digit <= w_q[r_sel];
         r_an    <= an_pattern(r_sel);
      end
   end

   assign digit = r_digit;
   assign an    = r_an;
   assign wrap  = r_wrap;

endmodule

// File: tb/tb_klingon_scan.sv
// Self-checking bench: phase table plus per-cycle scoreboard against a decimal model.
module tb_klingon_scan;

   localparam int SD = 4;
   localparam int CD = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] digit;
   logic [3:0] an;
   logic       wrap;

   klingon_scan #(
      .SCAN_DIV  (SD),
      .COUNT_DIV (CD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (clr),
      .digit (digit),
      .an    (an),
      .wrap  (wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] digit;
      logic [3:0] an;
      logic       wrap;
   } exp_t;

   typedef struct {
      string name;
      bit    rst;
      bit    en;
      bit    tog;
      bit    clr;
      int    cycles;
      int    exp_cnt;    // -1: no readback
      int    exp_wraps;  // -1: not checked
   } phase_t;

   exp_t q_exp[$];
   int   total = 0;
   int   bad = 0;
   int   n_wrap = 0;
   int   cyc = 0;

   // Reference model state
   int         m_cnt = 0, m_presc = 0, m_scan = 0, m_sel = 0;
   logic [3:0] m_digit = 0, m_an = 4'b1110;
   logic       m_wrap = 0, m_wpend = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s @cycle %0d: got %0h, required %0h", name, cyc, act, req);
      end
   endtask

   function automatic int dec_digit(input int cnt, input int sel);
      case (sel)
         0: return cnt % 10;
         1: return (cnt / 10) % 10;
         2: return (cnt / 100) % 10;
         default: return (cnt / 1000) % 10;
      endcase
   endfunction

   task automatic step(input bit r, input bit e, input bit c);
      exp_t x;
      bit   tick;
      reset = r; en = e; clr = c;
      @(posedge clk);
      cyc++;
      if (r) begin
         m_cnt = 0; m_presc = 0; m_scan = 0; m_sel = 0;
         m_digit = 0; m_an = 4'b1110; m_wrap = 0; m_wpend = 0;
      end else begin
         m_digit = 4'(dec_digit(m_cnt, m_sel));
         m_an    = ~(4'b0001 << m_sel);
         m_wrap  = m_wpend;
         m_wpend = 0;
         tick    = e && (m_presc == CD - 1);
         if (c) begin
            m_cnt = 0; m_presc = 0;
         end else if (e) begin
            if (tick) begin
               m_presc = 0;
               if (m_cnt == 9999) begin
                  m_cnt = 0; m_wpend = 1;
               end else begin
                  m_cnt++;
               end
            end else begin
               m_presc++;
            end
         end
         if (m_scan == SD - 1) begin
            m_scan = 0; m_sel = (m_sel + 1) % 4;
         end else begin
            m_scan++;
         end
      end
      x.digit = m_digit; x.an = m_an; x.wrap = m_wrap;
      q_exp.push_back(x);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (q_exp.size() > 0) begin
         x = q_exp.pop_front();
         check("digit", 32'(digit), 32'(x.digit));
         check("an",    32'(an),    32'(x.an));
         check("wrap",  32'(wrap),  32'(x.wrap));
         if (wrap === 1'b1) n_wrap++;
      end
   end

   // Frozen-count readback: sweep all positions and assemble the displayed value.
   task automatic read_count(output int val);
      int seen [4];
      for (int p = 0; p < 4; p++) seen[p] = -1;
      for (int i = 0; i < 4 * SD + 2; i++) begin
         step(1'b0, 1'b0, 1'b0);
         case (an)
            4'b1110: seen[0] = int'(digit);
            4'b1101: seen[1] = int'(digit);
            4'b1011: seen[2] = int'(digit);
            4'b0111: seen[3] = int'(digit);
            default: ;
         endcase
      end
      val = seen[3] * 1000 + seen[2] * 100 + seen[1] * 10 + seen[0];
      for (int p = 0; p < 4; p++) if (seen[p] < 0) val = -1;
   endtask

   phase_t tbl [12];

   initial begin
      int v, w0, hold, k;
      tbl[0]  = '{"reset3",   1, 0, 0, 0, 3,     0,    0};
      tbl[1]  = '{"count20",  0, 1, 0, 0, 40,    20,   0};
      tbl[2]  = '{"rst_a",    1, 0, 0, 0, 1,     -1,   -1};
      tbl[3]  = '{"preload",  0, 1, 0, 0, 19998, 9999, 0};
      tbl[4]  = '{"rollover", 0, 1, 0, 0, 2,     0,    1};
      tbl[5]  = '{"rst_b",    1, 0, 0, 0, 1,     -1,   -1};
      tbl[6]  = '{"to0123",   0, 1, 0, 0, 246,   123,  0};
      tbl[7]  = '{"pre_tick", 0, 1, 0, 0, 1,     -1,   -1};
      tbl[8]  = '{"clr_tick", 0, 1, 0, 1, 1,     0,    0};
      tbl[9]  = '{"presc0",   0, 1, 0, 0, 1,     0,    0};
      tbl[10] = '{"rst_c",    1, 0, 0, 0, 1,     -1,   -1};
      tbl[11] = '{"toggle",   0, 1, 1, 0, 8,     2,    0};

      @(negedge clk);
      for (int t = 0; t < 12; t++) begin
         w0 = n_wrap;
         for (int i = 0; i < tbl[t].cycles; i++)
            step(tbl[t].rst, tbl[t].tog ? (i % 2 == 0) : tbl[t].en, tbl[t].clr);
         if (t == 0) begin
            check("reset_an",    32'(an),    32'h e);
            check("reset_digit", 32'(digit), 32'h0);
            check("reset_wrap",  32'(wrap),  32'h0);
            // First non-idle position must be held exactly SD cycles.
            hold = 0;
            for (int i = 0; i < 3 * SD; i++) begin
               step(1'b0, 1'b0, 1'b0);
               if (an == 4'b1101) hold++;
            end
            check("an_hold_1101", 32'(hold), 32'(SD));
         end
         if (tbl[t].exp_cnt >= 0) begin
            read_count(v);
            check({tbl[t].name, "_count"}, 32'(v), 32'(tbl[t].exp_cnt));
         end
         if (tbl[t].exp_wraps >= 0)
            check({tbl[t].name, "_wraps"}, 32'(n_wrap - w0), 32'(tbl[t].exp_wraps));
      end

      // Mid-operation reset at 0457 while sel = 2.
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 914; i++) step(1'b0, 1'b1, 1'b0);
      read_count(v);
      check("mid_count", 32'(v), 32'd457);
      k = 0;
      while (m_sel != 2 && k < 4 * SD + 1) begin
         step(1'b0, 1'b0, 1'b0);
         k++;
      end
      check("mid_sel_reached", 32'(m_sel), 32'd2);
      step(1'b1, 1'b0, 1'b0);
      check("mid_rst_an",    32'(an),    32'h e);
      check("mid_rst_digit", 32'(digit), 32'h0);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0);
      read_count(v);
      check("mid_restart", 32'(v), 32'd1);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
